// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Constants and types shared by the write side and the read-mux side of the
// 8-entry register bank.
//   NUM_REGS   : number of entries (A..H)
//   ADDR_W     : entry index width
//   DEF_DATA_W : default entry width
//   state_e    : write-side sequencer states
// -----------------------------------------------------------------------------
package reg_bank_pkg;

   localparam int unsigned NUM_REGS   = 8;
   localparam int unsigned ADDR_W     = 3;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_write_8x16_if.sv
// -----------------------------------------------------------------------------
// reg_bank_write_8x16_if
// Write-request channel of the register bank (valid/ready handshake).
//   wr_valid : request present            (master -> slave)
//   wr_addr  : target entry, 0=A .. 7=H   (master -> slave)
//   wr_data  : write data                 (master -> slave)
//   wr_ready : slave accepts this cycle   (slave  -> master)
// -----------------------------------------------------------------------------
interface reg_bank_write_8x16_if
   import reg_bank_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
);

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface : reg_bank_write_8x16_if

// File: rtl/decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
// Combinational one-hot decoder with enable; the dual of the 8-to-1 read mux.
//   en     : when low the output is all zeros
//   sel    : index to decode
//   onehot : 1 << sel when enabled
// -----------------------------------------------------------------------------
module decoder_3to8
   import reg_bank_pkg::*;
(
   input  logic                en,
   input  logic [ADDR_W-1:0]   sel,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      // NOTE: assign a default before any condition so every path drives
      // onehot; otherwise a latch is inferred.
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule : decoder_3to8

// File: rtl/reg_bank_write_8x16.sv
// -----------------------------------------------------------------------------
// reg_bank_write_8x16
// Write side of the 8-entry register bank. Accepts writes over a valid/ready
// handshake and runs a multi-cycle sweep that loads CLEAR_VALUE into every
// entry. One decoder serves both the write address and the sweep counter.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous, active-high reset
//   Enable    : block enable; low blocks writes and pauses the sweep
//   wr_if     : write channel (slave side)
//   clr_req   : one-cycle request to start a sweep
//   busy      : sweep in progress
//   wr_strobe : one-hot of the entry written on the previous edge
//   A..H      : entry contents, feeding the read mux
//
// Build option
//   REG0_ZERO_EN : entry A is hardwired to zero; writes to it complete the
//                  handshake without effect and the sweep skips index 0.
// -----------------------------------------------------------------------------
module reg_bank_write_8x16
   import reg_bank_pkg::*;
#(
   parameter int unsigned       DATA_W      = DEF_DATA_W,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       Enable,
   reg_bank_write_8x16_if.slave       wr_if,
   input  logic                       clr_req,
   output logic                       busy,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic [DATA_W-1:0]          A,
   output logic [DATA_W-1:0]          B,
   output logic [DATA_W-1:0]          C,
   output logic [DATA_W-1:0]          D,
   output logic [DATA_W-1:0]          E,
   output logic [DATA_W-1:0]          F,
   output logic [DATA_W-1:0]          G,
   output logic [DATA_W-1:0]          H
);

`ifdef REG0_ZERO_EN
   localparam logic [ADDR_W-1:0]   FIRST_IDX = 3'd1;
   localparam logic [NUM_REGS-1:0] WR_MASK   = 8'hFE;
`else
   localparam logic [ADDR_W-1:0]   FIRST_IDX = 3'd0;
   localparam logic [NUM_REGS-1:0] WR_MASK   = 8'hFF;
`endif
   localparam logic [ADDR_W-1:0]   LAST_IDX  = 3'd7;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];

   logic                wr_fire;
   logic                dec_en;
   logic [ADDR_W-1:0]   dec_sel;
   logic [NUM_REGS-1:0] dec_onehot;
   logic [DATA_W-1:0]   wdata;

   // clr_req takes priority: it withdraws ready in the same cycle.
   assign wr_if.wr_ready = Enable & (state_q == IDLE) & ~clr_req & ~rst;
   assign wr_fire        = wr_if.wr_valid & wr_if.wr_ready;

   // Sequencer and decoder source select: write address in IDLE, sweep
   // counter in CLEAR.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dec_sel = wr_if.wr_addr;
      dec_en  = wr_fire;
      wdata   = wr_if.wr_data;
      unique case (state_q)
         IDLE: begin
            if (clr_req && Enable) begin
               state_d = CLEAR;
               cnt_d   = FIRST_IDX;
            end
         end
         CLEAR: begin
            dec_sel = cnt_q;
            dec_en  = Enable;
            wdata   = CLEAR_VALUE;
            if (Enable) begin
               // The 3-bit counter wraps 7->0 on the same edge as the exit.
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   decoder_3to8 u_dec (
      .en     (dec_en),
      .sel    (dec_sel),
      .onehot (dec_onehot)
   );

   // Masking entry 0 here blocks both its write and its strobe.
   assign wr_strobe_d = dec_onehot & WR_MASK;

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = wr_strobe_d[i] ? wdata : regs_q[i];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_strobe_q <= '0;
         // NOTE: the entries themselves are reset because A..H must read zero
         // after reset; the read mux has no valid qualifier.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_strobe_q <= wr_strobe_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign busy      = (state_q == CLEAR);
   assign wr_strobe = wr_strobe_q;

`ifdef REG0_ZERO_EN
   assign A = '0;
`else
   assign A = regs_q[0];
`endif
   assign B = regs_q[1];
   assign C = regs_q[2];
   assign D = regs_q[3];
   assign E = regs_q[4];
   assign F = regs_q[5];
   assign G = regs_q[6];
   assign H = regs_q[7];

endmodule : reg_bank_write_8x16

// File: tb/tb_reg_bank_write_8x16.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_write_8x16
// Directed bench for the register-bank write side. Stimulus pushes the
// expected strobe and full register image for every write it issues; a
// monitor on the falling edge pops an entry whenever wr_strobe is non-zero.
// -----------------------------------------------------------------------------
module tb_reg_bank_write_8x16;

   localparam logic [15:0] CLR_VAL = 16'h0000;
`ifdef REG0_ZERO_EN
   localparam bit          REG0    = 1'b1;
   localparam int          FIRST   = 1;
`else
   localparam bit          REG0    = 1'b0;
   localparam int          FIRST   = 0;
`endif

   typedef struct packed {
      logic [7:0]       strobe;
      logic [7:0][15:0] regs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        Enable;
   logic        clr_req;
   logic        busy;
   logic [7:0]  wr_strobe;
   logic [15:0] A, B, C, D, E, F, G, H;

   exp_t             exp_q[$];
   logic [7:0][15:0] exp_regs;
   int               n_vec = 0;
   int               n_err = 0;

   reg_bank_write_8x16_if #(.DATA_W(16)) wr_if ();

   reg_bank_write_8x16 #(.DATA_W(16), .CLEAR_VALUE(CLR_VAL)) dut (
      .clk       (clk),
      .rst       (rst),
      .Enable    (Enable),
      .wr_if     (wr_if.slave),
      .clr_req   (clr_req),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .A (A), .B (B), .C (C), .D (D),
      .E (E), .F (F), .G (G), .H (H)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (the drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] s);
      exp_t it;
      it.strobe = s;
      it.regs   = exp_regs;
      exp_q.push_back(it);
   endtask

   task automatic check_all_zero(input string tag);
      logic [7:0][15:0] act;
      act = {H, G, F, E, D, C, B, A};
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_reg%0d", tag, i), act[i], 0);
      end
   endtask

   task automatic do_write(input logic [2:0] a, input logic [15:0] d);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr  = a;
      wr_if.wr_data  = d;
      #1 check($sformatf("ready_wr_a%0d", a), wr_if.wr_ready, 1);
      if (!(REG0 && a == 3'd0)) begin
         exp_regs[a] = d;
         push_exp(8'd1 << a);
      end
      step();
   endtask

   // Clear sweep driven cycle by cycle. Negative arguments disable the
   // pause, the mid-sweep clr_req and the reset abort respectively.
   task automatic run_clear(input int pause_at, input int pause_len,
                            input int reclr_at, input int abort_at);
      clr_req        = 1'b1;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_addr  = 3'd5;
      wr_if.wr_data  = 16'hFFFF;
      #1 check("ready_low_on_clr_req", wr_if.wr_ready, 0);
      step();
      clr_req        = 1'b0;
      wr_if.wr_valid = 1'b0;
      for (int idx = FIRST; idx < 8; idx++) begin
         if (idx == pause_at) begin
            Enable = 1'b0;
            for (int p = 0; p < pause_len; p++) begin
               #1 check($sformatf("busy_pause%0d", p), busy, 1);
               step();
            end
            Enable = 1'b1;
         end
         if (idx == abort_at) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            exp_regs = '0;
            #1;
            check_all_zero("abort");
            check("abort_busy", busy, 0);
            check("abort_strobe", wr_strobe, 0);
            check("abort_ready", wr_if.wr_ready, 1);
            return;
         end
         clr_req = (idx == reclr_at);
         #1;
         check($sformatf("busy_clr%0d", idx), busy, 1);
         check($sformatf("ready_clr%0d", idx), wr_if.wr_ready, 0);
         exp_regs[idx] = CLR_VAL;
         push_exp(8'd1 << idx);
         step();
      end
      clr_req = 1'b0;
      #1;
      check("busy_after_sweep", busy, 0);
      check("ready_after_sweep", wr_if.wr_ready, 1);
   endtask

   // Scoreboard monitor: every strobe must match the next expected write.
   always @(negedge clk) begin
      exp_t             it;
      logic [7:0][15:0] act;
      if (wr_strobe !== 8'h00) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", wr_strobe, 0);
         end else begin
            it  = exp_q.pop_front();
            act = {H, G, F, E, D, C, B, A};
            check("strobe", wr_strobe, it.strobe);
            for (int i = 0; i < 8; i++) begin
               check($sformatf("reg%0d", i), act[i], it.regs[i]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst            = 1'b1;
      Enable         = 1'b1;
      clr_req        = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_addr  = '0;
      wr_if.wr_data  = '0;
      exp_regs       = '0;

      // Reset state.
      repeat (2) step();
      check("ready_in_reset", wr_if.wr_ready, 0);
      check_all_zero("rst");
      check("rst_busy", busy, 0);
      check("rst_strobe", wr_strobe, 0);
      rst = 1'b0;
      #1 check("ready_after_rst", wr_if.wr_ready, 1);

      // Single write, strobe lasts one cycle.
      do_write(3'd3, 16'hBEEF);
      wr_if.wr_valid = 1'b0;
      step();
      check("strobe_one_cycle", wr_strobe, 0);
      check("d_holds", D, 16'hBEEF);

      // Enable low blocks writes.
      Enable = 1'b0;
      wr_if.wr_valid = 1'b1;
      #1 check("ready_enable_low", wr_if.wr_ready, 0);
      step();
      wr_if.wr_valid = 1'b0;
      Enable = 1'b1;

      // Eight back-to-back writes.
      for (int i = 0; i < 8; i++) begin
         do_write(3'(i), 16'h1110 + 16'(i));
      end
      // Same address twice, last write wins.
      do_write(3'd6, 16'h6A6A);
      do_write(3'd6, 16'h6B6B);
      wr_if.wr_valid = 1'b0;
      step();

      // Full sweep with clr_req colliding with wr_valid.
      run_clear(-1, 0, -1, -1);

      // Sweep with a 3-cycle pause and a mid-sweep clr_req.
      for (int i = 0; i < 8; i++) begin
         do_write(3'(i), 16'h2220 + 16'(i));
      end
      wr_if.wr_valid = 1'b0;
      step();
      run_clear(3, 3, 5, -1);

      // Reset at clear cycle 4.
      do_write(3'd2, 16'hCAFE);
      do_write(3'd6, 16'hF00D);
      wr_if.wr_valid = 1'b0;
      step();
      run_clear(-1, 0, -1, 4);

`ifdef REG0_ZERO_EN
      // Entry A is hardwired: handshake completes, no strobe, A stays 0.
      do_write(3'd0, 16'h1234);
      wr_if.wr_valid = 1'b0;
      #1 check("reg0_a_zero", A, 0);
      check("reg0_no_strobe", wr_strobe, 0);
      do_write(3'd1, 16'h5555);
      wr_if.wr_valid = 1'b0;
      step();
      run_clear(-1, 0, -1, -1);
`endif

      repeat (2) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_reg_bank_write_8x16

// File: doc/reg_bank_write_8x16.md
Name: reg_bank_write_8x16

Overview:
- Write side of the 8-entry, 16-bit register bank.
- Accepts write requests over a valid/ready handshake and decodes the 3-bit address to a one-hot write strobe.
- Holds eight registers whose outputs A..H drive the existing 8-to-1 16-bit read mux.
- Also provides a multi-cycle clear sequence that zeroes (or presets) every entry.

Parameters:
- DATA_W, 16, register width.
- CLEAR_VALUE, 16'h0000, value written to each entry during a clear sweep.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- Enable  input  1  block enable; when low, no writes are accepted and the clear sweep pauses.
- wr_valid  input  1  write request present.
- wr_ready  output  1  block can accept a write this cycle.
- wr_addr  input  3  target register index (0=A … 7=H).
- wr_data  input  DATA_W  write data.
- clr_req  input  1  one-cycle request to start a clear sweep.
- busy  output  1  clear sweep in progress.
- wr_strobe  output  8  registered one-hot copy of the enable for the entry written last cycle; zero otherwise.
- A,B,C,D,E,F,G,H  output  DATA_W each  register contents, feeding the read mux.

Behaviour:
- Reset (rst=1 at a clock edge):
  - A..H = 0; state = IDLE; clear counter = 0; busy = 0; wr_strobe = 0.
  - Reset overrides everything, including a clear sweep in progress.
- wr_ready = Enable & (state==IDLE) & ~clr_req & ~rst. It is combinational.
- Write:
  - A write fires when wr_valid & wr_ready are high at the clock edge.
  - Register[wr_addr] <= wr_data; the new value is visible on its output the next cycle (1-cycle latency).
  - The same edge sets wr_strobe = 1<<wr_addr for exactly one cycle.
  - Back-to-back writes are allowed every cycle, including repeated writes to the same address (last write wins).
- States: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req & Enable. The counter loads 0 and busy = 1 from the next cycle.
  - clr_req has priority over wr_valid in the same cycle: no write is accepted that cycle.
  - CLEAR: each cycle with Enable=1, register[counter] <= CLEAR_VALUE, wr_strobe = 1<<counter, and the counter increments.
  - With Enable=0 in CLEAR, the counter holds, nothing is written and wr_strobe = 0.
  - CLEAR -> IDLE after the write to index 7 (8 enabled cycles). busy drops on the cycle after the index-7 write.
  - clr_req while in CLEAR is ignored; it does not restart the sweep.
  - wr_ready = 0 for the whole of CLEAR.
- Counter: 3 bits, wraps 7->0 naturally; the wrap coincides with the return to IDLE.
- X on wr_addr or wr_data is never written unless the handshake fires.

Optional Feature:
- Macro REG0_ZERO_EN.
- Defined:
  - Register A is hardwired to 0.
  - Writes to address 0 complete the handshake, but wr_strobe stays 0 and A stays 0.
  - The clear sweep skips index 0 and takes 7 enabled cycles.
- Undefined: A behaves like every other entry.

Decomposition:
- Shared package reg_bank_pkg:
  - NUM_REGS=8, ADDR_W=3, DATA_W default 16.
  - State enum {IDLE, CLEAR}.
  - The same constants are used by the read-mux side.
- One natural sub-module: decoder_3to8.
  - Combinational one-hot decode with an enable input.
  - It is the dual of the read mux and is reused for both the write-address and clear-counter paths via a 2:1 select on its input.

Test Plan:
1. Reset then write 16'hBEEF to addr 3 with Enable=1 -> D=BEEF next cycle, wr_strobe=8'b0000_1000 for one cycle, other outputs 0.
2. 8 back-to-back writes (addr i, data 16'h1110+i) -> A..H = 1110..1117, wr_ready high throughout.
3. After case 2, pulse clr_req with wr_valid also high -> no write that cycle. busy=1 for 8 cycles, and wr_strobe walks 01,02,…,80. All outputs = 0 afterwards; busy=0 and wr_ready=1 on cycle 9.
4. Clear with Enable dropped for 3 cycles mid-sweep -> sweep stretches to 11 cycles, with no strobes during the pause. A second clr_req mid-sweep has no effect.
5. rst asserted at clear cycle 4 -> next cycle all outputs 0, busy=0, state IDLE, wr_ready=1.
6. REG0_ZERO_EN build: write 16'h1234 to addr 0 -> handshake completes, A=0, wr_strobe=0. The clear sweep takes 7 cycles with strobes 02…80.
